// File: rtl/demux_1_n_stream.sv
// demux_1_n_stream: registered 1-to-OUTPUTS stream demultiplexer.
// One input word is steered to the channel picked by in_sel. Each channel
// has a one-entry holding slot, so a stalled consumer only blocks words
// aimed at its own channel.
// Optional feature macro: DEMUX_ERR_CNT_EN adds a saturating 16-bit count
// of accepted words whose in_sel is out of range (err_count port).
module demux_1_n_stream #(
  parameter  int N       = 32,
  parameter  int OUTPUTS = 4,
  localparam int SEL_W   = $clog2(OUTPUTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_data,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUTPUTS*N-1:0] out_data,
  output logic [OUTPUTS-1:0]   out_valid,
  input  logic [OUTPUTS-1:0]   out_ready
`ifdef DEMUX_ERR_CNT_EN
  ,
  output logic [15:0]          err_count
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  logic [OUTPUTS-1:0] sel_hit;    // one-hot decode of in_sel, all-zero if out of range
  logic [OUTPUTS-1:0] slot_free;  // slot can take a word this cycle
  logic               sel_valid;
  logic               load;

  // Decode the select and the per-slot acceptance condition. Comparing
  // against each index avoids a constant range check when OUTPUTS is 2^SEL_W.
  generate
    for (genvar gi = 0; gi < OUTPUTS; gi++) begin : g_decode
      assign sel_hit[gi]   = (in_sel == SEL_W'(gi));
      assign slot_free[gi] = !out_valid[gi] | out_ready[gi];
    end
  endgenerate

  assign sel_valid = |sel_hit;
  // Out-of-range selects are always accepted and discarded.
  assign in_ready  = sel_valid ? |(sel_hit & slot_free) : 1'b1;
  assign load      = in_valid & in_ready;

  // One holding slot per channel. A load wins over a drain, which gives
  // back-to-back throughput when the consumer drains every cycle.
  generate
    for (genvar gi = 0; gi < OUTPUTS; gi++) begin : g_slot
      slot_state_t state_reg;
      logic [N-1:0] data_reg;

      // Per-slot EMPTY/FULL state machine with its data register.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_reg <= EMPTY;
          data_reg  <= '0;
        end else begin
          case (state_reg)
            EMPTY: begin
              if (load && sel_hit[gi]) begin
                state_reg <= FULL;
                data_reg  <= in_data;
              end
            end
            FULL: begin
              if (load && sel_hit[gi]) begin
                data_reg <= in_data;
              end else if (out_ready[gi]) begin
                state_reg <= EMPTY;
              end
            end
            default: state_reg <= EMPTY;
          endcase
        end
      end

      assign out_valid[gi]         = (state_reg == FULL);
      assign out_data[gi*N +: N]   = data_reg;
    end
  endgenerate

`ifdef DEMUX_ERR_CNT_EN
  logic [15:0] err_count_reg;

  // Count accepted out-of-range words, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count_reg <= '0;
    end else if (in_valid && !sel_valid && (err_count_reg != 16'hFFFF)) begin
      err_count_reg <= err_count_reg + 16'd1;
    end
  end

  assign err_count = err_count_reg;
`endif

endmodule

// File: tb/tb_demux_1_n_stream.sv
// Testbench for demux_1_n_stream: directed scenarios plus random traffic,
// checked against a per-channel "held word" model. A second instance with
// OUTPUTS=3 exercises out-of-range selects (and err_count when
// DEMUX_ERR_CNT_EN is defined).
module tb_demux_1_n_stream;

  logic         clk;
  logic         rst;

  // Main instance, OUTPUTS=4
  logic [31:0]  in_data;
  logic [1:0]   in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] out_data;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;

  // Second instance, OUTPUTS=3
  logic [31:0]  in_data3;
  logic [1:0]   in_sel3;
  logic         in_valid3;
  logic         in_ready3;
  logic [95:0]  out_data3;
  logic [2:0]   out_valid3;
  logic [2:0]   out_ready3;
`ifdef DEMUX_ERR_CNT_EN
  logic [15:0]  err_count;
  logic [15:0]  err_count3;
`endif

  int n_checks = 0;
  int n_fails  = 0;
  int n_txn    = 0;

  // Reference model: what each channel currently holds
  logic         mdl_valid [4];
  logic [31:0]  mdl_data  [4];

  demux_1_n_stream #(.N(32), .OUTPUTS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DEMUX_ERR_CNT_EN
    ,
    .err_count (err_count)
`endif
  );

  demux_1_n_stream #(.N(32), .OUTPUTS(3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data3),
    .in_sel    (in_sel3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .out_data  (out_data3),
    .out_valid (out_valid3),
    .out_ready (out_ready3)
`ifdef DEMUX_ERR_CNT_EN
    ,
    .err_count (err_count3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      mdl_valid[k] = 1'b0;
      mdl_data[k]  = '0;
    end
  endtask

  // One clock cycle on the main instance. Called at posedge+1; drives the
  // inputs, checks outputs against the model, then advances the model.
  task automatic cycle(input logic v, input logic [1:0] sel, input logic [31:0] d,
                       input logic [3:0] rdy);
    logic exp_ready;
    logic [3:0] exp_valid;
    in_valid  = v;
    in_sel    = sel;
    in_data   = d;
    out_ready = rdy;
    #1;
    exp_ready = !mdl_valid[sel] || rdy[sel];
    for (int k = 0; k < 4; k++) exp_valid[k] = mdl_valid[k];
    check("in_ready", {63'b0, in_ready}, {63'b0, exp_ready});
    check("out_valid", {60'b0, out_valid}, {60'b0, exp_valid});
    for (int k = 0; k < 4; k++) begin
      if (mdl_valid[k]) check($sformatf("out_data[%0d]", k), {32'b0, out_data[k*32 +: 32]}, {32'b0, mdl_data[k]});
    end
    $display("txn %0d v=%0b sel=%0d data=%h rdy=%b in_ready=%0b out_valid=%b",
             n_txn, v, sel, d, rdy, in_ready, out_valid);
    n_txn++;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (mdl_valid[k] && rdy[k]) mdl_valid[k] = 1'b0;
    end
    if (v && exp_ready) begin
      mdl_valid[sel] = 1'b1;
      mdl_data[sel]  = d;
    end
    #1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 0; in_sel = 0; in_data = 0; out_ready = 0;
    in_valid3 = 0; in_sel3 = 0; in_data3 = 0; out_ready3 = 0;
    model_clear();
    @(posedge clk); @(posedge clk); #1;
    check("reset_valid", {60'b0, out_valid}, 64'd0);
    check("reset_data_lo", out_data[63:0], 64'd0);
    check("reset_data_hi", out_data[127:64], 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single route to channel 2
    cycle(1'b1, 2'd2, 32'h0000_0004, 4'b0000);
    check("route_valid", {60'b0, out_valid}, 64'b0100);
    check("route_data", {32'b0, out_data[95:64]}, 64'h4);
    cycle(1'b0, 2'd0, 32'h0, 4'b0100);

    // Reset mid-cycle with slot 2 full
    cycle(1'b1, 2'd2, 32'h0000_0055, 4'b0000);
    in_valid = 0;
    #3 rst = 1'b1;
    #1;
    check("midrst_valid", {60'b0, out_valid}, 64'd0);
    check("midrst_data_hi", out_data[127:64], 64'd0);
    model_clear();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    cycle(1'b0, 2'd2, 32'h0, 4'b0000);

    // Back-pressure on channel 1, then channel 3 still accepts
    cycle(1'b1, 2'd1, 32'h0000_00B1, 4'b0000);
    for (int i = 0; i < 5; i++) cycle(1'b1, 2'd1, 32'h0000_00B2 + i, 4'b0000);
    check("bp_hold", {32'b0, out_data[63:32]}, 64'hB1);
    cycle(1'b1, 2'd3, 32'h0000_00B3, 4'b0000);
    check("bp_other_valid", {60'b0, out_valid}, 64'b1010);
    cycle(1'b0, 2'd0, 32'h0, 4'b1111);

    // Full throughput rotating over channels
    for (int i = 0; i <= 30; i++) cycle(1'b1, 2'(i % 4), 32'(1) << i, 4'b1111);
    cycle(1'b0, 2'd0, 32'h0, 4'b1111);

    // Simultaneous drain and load on channel 0
    cycle(1'b1, 2'd0, 32'h0000_000A, 4'b0000);
    cycle(1'b1, 2'd0, 32'h0000_000B, 4'b0001);
    check("dl_data", {32'b0, out_data[31:0]}, 64'hB);
    check("dl_valid", {63'b0, out_valid[0]}, 64'd1);
    cycle(1'b0, 2'd0, 32'h0, 4'b1111);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom % 4) != 0, 2'($urandom_range(0, 3)), $urandom, 4'($urandom));
    end

    // OUTPUTS=3 instance: out-of-range select is accepted and dropped
    in_valid3 = 1; in_sel3 = 2'd1; in_data3 = 32'h0000_00C1; out_ready3 = 3'b000;
    #1;
    check("n3_load_ready", {63'b0, in_ready3}, 64'd1);
    @(posedge clk); #1;
    check("n3_load_valid", {61'b0, out_valid3}, 64'b010);
    for (int r = 0; r < 3; r++) begin
      in_valid3 = 1; in_sel3 = 2'd3; in_data3 = $urandom;
      #1;
      check("n3_bad_ready", {63'b0, in_ready3}, 64'd1);
      $display("txn %0d n3 v=1 sel=3 data=%h in_ready=%0b out_valid=%b",
               n_txn, in_data3, in_ready3, out_valid3);
      n_txn++;
      @(posedge clk); #1;
      check("n3_bad_valid", {61'b0, out_valid3}, 64'b010);
      check("n3_bad_data", {32'b0, out_data3[63:32]}, 64'hC1);
    end
    in_valid3 = 0;
`ifdef DEMUX_ERR_CNT_EN
    check("err_count", {48'b0, err_count3}, 64'd3);
    force dut3.err_count_reg = 16'hFFFF;
    @(posedge clk); #1;
    release dut3.err_count_reg;
    in_valid3 = 1; in_sel3 = 2'd3;
    @(posedge clk); #1;
    in_valid3 = 0;
    check("err_sat", {48'b0, err_count3}, 64'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
